// File: rtl/generator_descriptor_fifo.sv
// generator_descriptor_fifo
// Builds {channel, pause, length} descriptors from fixed config or from
// in-range LFSR samples and queues them in a first-word-fall-through FIFO so
// generation can run ahead of the packet former.
// Optional: define GENERATOR_DESCRIPTOR_STAT_EN to add the reject/descriptor
// statistics counters (sts_reject_cnt_o, sts_descr_cnt_o).
module generator_descriptor_fifo #(
  parameter int LEN_W      = 16,
  parameter int ID_W       = 10,
  parameter int PAUSE_W    = 32,
  parameter int FIFO_DEPTH = 8,
  localparam int AW = $clog2(FIFO_DEPTH),
  localparam int DW = ID_W + PAUSE_W + LEN_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cntrl_start_i,
  input  logic               cntrl_stop_i,
  input  logic               cntrl_auto_length_i,
  input  logic               cntrl_auto_channel_i,
  input  logic               cntrl_auto_pause_i,
  input  logic               cntrl_use_limit_transaction_i,
  input  logic [LEN_W-1:0]   cntrl_fixed_length_i,
  input  logic [LEN_W-1:0]   cntrl_min_length_i,
  input  logic [LEN_W-1:0]   cntrl_max_length_i,
  input  logic [ID_W-1:0]    cntrl_fixed_channel_i,
  input  logic [ID_W-1:0]    cntrl_min_channel_i,
  input  logic [ID_W-1:0]    cntrl_max_channel_i,
  input  logic [PAUSE_W-1:0] cntrl_fixed_pause_i,
  input  logic [PAUSE_W-1:0] cntrl_min_pause_i,
  input  logic [PAUSE_W-1:0] cntrl_max_pause_i,
  input  logic [31:0]        cntrl_cnt_packet_i,
  input  logic [LEN_W-1:0]   pkt_length_i,
  input  logic [ID_W-1:0]    pkt_channel_i,
  input  logic [PAUSE_W-1:0] pkt_pause_i,
  output logic [DW-1:0]      descriptor_data_o,
  output logic               descriptor_valid_o,
  input  logic               descriptor_ready_i,
  output logic               sts_busy_o,
  output logic               sts_done_o,
  output logic               sts_cfg_err_o,
  output logic [AW:0]        sts_fifo_level_o
`ifdef GENERATOR_DESCRIPTOR_STAT_EN
  ,
  output logic [31:0]        sts_reject_cnt_o,
  output logic [31:0]        sts_descr_cnt_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_PUSH} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(FIFO_DEPTH);

  state_t state_q, state_d;

  // latched run configuration
  logic               auto_len_q, auto_ch_q, auto_pa_q, use_lim_q;
  logic [LEN_W-1:0]   fix_len_q, min_len_q, max_len_q;
  logic [ID_W-1:0]    fix_ch_q, min_ch_q, max_ch_q;
  logic [PAUSE_W-1:0] fix_pa_q, min_pa_q, max_pa_q;
  logic [31:0]        remaining_q;

  // descriptor under construction
  logic [LEN_W-1:0]   len_q;
  logic [ID_W-1:0]    ch_q;
  logic [PAUSE_W-1:0] pa_q;
  logic               ok_len_q, ok_ch_q, ok_pa_q;

  // FIFO
  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;

  logic done_pend_q, done_q, cfg_err_q;

  logic cfg_ok, start_req, start_acc, start_rej;
  logic len_hit, ch_hit, pa_hit;
  logic len_ok_nxt, ch_ok_nxt, pa_ok_nxt, all_ok, gen_reject;
  logic fifo_full, fifo_empty, push, pop, last, flush;

  assign cfg_ok = (!cntrl_use_limit_transaction_i || cntrl_cnt_packet_i != 32'd0)
               && (cntrl_auto_length_i ? (cntrl_max_length_i >= cntrl_min_length_i)
                                       : (cntrl_fixed_length_i != '0))
               && (!cntrl_auto_channel_i || cntrl_max_channel_i >= cntrl_min_channel_i)
               && (!cntrl_auto_pause_i || cntrl_max_pause_i >= cntrl_min_pause_i);

  // stop takes priority over a simultaneous start
  assign start_req = (state_q == S_IDLE) && cntrl_start_i && !cntrl_stop_i;
  assign start_acc = start_req && cfg_ok;
  assign start_rej = start_req && !cfg_ok;

  // a field hits on the first in-range sample while still pending
  assign len_hit = auto_len_q && !ok_len_q && pkt_length_i  >= min_len_q && pkt_length_i  <= max_len_q;
  assign ch_hit  = auto_ch_q  && !ok_ch_q  && pkt_channel_i >= min_ch_q  && pkt_channel_i <= max_ch_q;
  assign pa_hit  = auto_pa_q  && !ok_pa_q  && pkt_pause_i   >= min_pa_q  && pkt_pause_i   <= max_pa_q;

  assign len_ok_nxt = !auto_len_q || ok_len_q || len_hit;
  assign ch_ok_nxt  = !auto_ch_q  || ok_ch_q  || ch_hit;
  assign pa_ok_nxt  = !auto_pa_q  || ok_pa_q  || pa_hit;
  assign all_ok     = len_ok_nxt && ch_ok_nxt && pa_ok_nxt;
  assign gen_reject = (auto_len_q && !ok_len_q && !len_hit)
                   || (auto_ch_q  && !ok_ch_q  && !ch_hit)
                   || (auto_pa_q  && !ok_pa_q  && !pa_hit);

  assign fifo_full  = (count_q == DEPTH_L);
  assign fifo_empty = (count_q == '0);
  assign flush      = cntrl_stop_i;
  assign pop        = !fifo_empty && descriptor_ready_i && !flush;
  // a full FIFO still accepts a write when the same edge pops the head
  assign push       = (state_q == S_PUSH) && !flush && (!fifo_full || pop);
  assign last       = use_lim_q && (remaining_q == 32'd1);

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_acc) state_d = S_GEN;
      S_GEN: begin
        if (cntrl_stop_i) state_d = S_IDLE;
        else if (all_ok)  state_d = S_PUSH;
      end
      S_PUSH: begin
        if (cntrl_stop_i) state_d = S_IDLE;
        else if (push)    state_d = last ? S_IDLE : S_GEN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // configuration is sampled only when a start is accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      auto_len_q <= 1'b0; auto_ch_q <= 1'b0; auto_pa_q <= 1'b0; use_lim_q <= 1'b0;
      fix_len_q  <= '0;   min_len_q <= '0;   max_len_q <= '0;
      fix_ch_q   <= '0;   min_ch_q  <= '0;   max_ch_q  <= '0;
      fix_pa_q   <= '0;   min_pa_q  <= '0;   max_pa_q  <= '0;
    end else if (start_acc) begin
      auto_len_q <= cntrl_auto_length_i;
      auto_ch_q  <= cntrl_auto_channel_i;
      auto_pa_q  <= cntrl_auto_pause_i;
      use_lim_q  <= cntrl_use_limit_transaction_i;
      fix_len_q  <= cntrl_fixed_length_i;  min_len_q <= cntrl_min_length_i;  max_len_q <= cntrl_max_length_i;
      fix_ch_q   <= cntrl_fixed_channel_i; min_ch_q  <= cntrl_min_channel_i; max_ch_q  <= cntrl_max_channel_i;
      fix_pa_q   <= cntrl_fixed_pause_i;   min_pa_q  <= cntrl_min_pause_i;   max_pa_q  <= cntrl_max_pause_i;
    end
  end

  // remaining-descriptor counter for limited runs
  always_ff @(posedge clk) begin
    if (reset)                 remaining_q <= '0;
    else if (start_acc)        remaining_q <= cntrl_cnt_packet_i;
    else if (push && use_lim_q) remaining_q <= remaining_q - 32'd1;
  end

  // field capture during GEN; ok flags drop whenever GEN is left
  always_ff @(posedge clk) begin
    if (reset) begin
      len_q <= '0; ch_q <= '0; pa_q <= '0;
      ok_len_q <= 1'b0; ok_ch_q <= 1'b0; ok_pa_q <= 1'b0;
    end else if (state_q == S_GEN) begin
      if (!auto_len_q)  len_q <= fix_len_q;
      else if (len_hit) len_q <= pkt_length_i;
      if (!auto_ch_q)   ch_q  <= fix_ch_q;
      else if (ch_hit)  ch_q  <= pkt_channel_i;
      if (!auto_pa_q)   pa_q  <= fix_pa_q;
      else if (pa_hit)  pa_q  <= pkt_pause_i;
      ok_len_q <= (state_d == S_GEN) && len_ok_nxt;
      ok_ch_q  <= (state_d == S_GEN) && ch_ok_nxt;
      ok_pa_q  <= (state_d == S_GEN) && pa_ok_nxt;
    end else begin
      ok_len_q <= 1'b0; ok_ch_q <= 1'b0; ok_pa_q <= 1'b0;
    end
  end

  // next FIFO occupancy
  always_comb begin
    count_d = count_q;
    if (flush) count_d = '0;
    else begin
      case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {ch_q, pa_q, len_q};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // done is armed by count exhaustion and fires once the FIFO has drained
  always_ff @(posedge clk) begin
    if (reset) begin
      done_pend_q <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= start_rej;
      done_q    <= 1'b0;
      if (flush || start_acc) done_pend_q <= 1'b0;
      else if (push && last)  done_pend_q <= 1'b1;
      else if (done_pend_q && count_d == '0) begin
        done_pend_q <= 1'b0;
        done_q      <= 1'b1;
      end
    end
  end

`ifdef GENERATOR_DESCRIPTOR_STAT_EN
  logic [31:0] rej_cnt_q, descr_cnt_q;

  // saturating statistics, cleared by an accepted start
  always_ff @(posedge clk) begin
    if (reset || start_acc) begin
      rej_cnt_q   <= '0;
      descr_cnt_q <= '0;
    end else begin
      if (state_q == S_GEN && gen_reject && rej_cnt_q != 32'hFFFF_FFFF) rej_cnt_q <= rej_cnt_q + 32'd1;
      if (push && descr_cnt_q != 32'hFFFF_FFFF) descr_cnt_q <= descr_cnt_q + 32'd1;
    end
  end

  assign sts_reject_cnt_o = rej_cnt_q;
  assign sts_descr_cnt_o  = descr_cnt_q;
`endif

  assign descriptor_valid_o = !fifo_empty;
  assign descriptor_data_o  = fifo_empty ? '0 : mem[rd_ptr_q];
  assign sts_busy_o         = (state_q != S_IDLE) || !fifo_empty;
  assign sts_done_o         = done_q;
  assign sts_cfg_err_o      = cfg_err_q;
  assign sts_fifo_level_o   = count_q;

endmodule

// File: tb/tb_generator_descriptor_fifo.sv
// Directed/randomised bench for generator_descriptor_fifo: drives LFSR-like
// samples and consumer ready, checks descriptors against config-derived rules.
module tb_generator_descriptor_fifo;
  logic        clk = 1'b0;
  logic        reset;
  logic        cntrl_start_i, cntrl_stop_i;
  logic        cntrl_auto_length_i, cntrl_auto_channel_i, cntrl_auto_pause_i, cntrl_use_limit_transaction_i;
  logic [15:0] cntrl_fixed_length_i, cntrl_min_length_i, cntrl_max_length_i;
  logic [9:0]  cntrl_fixed_channel_i, cntrl_min_channel_i, cntrl_max_channel_i;
  logic [31:0] cntrl_fixed_pause_i, cntrl_min_pause_i, cntrl_max_pause_i;
  logic [31:0] cntrl_cnt_packet_i;
  logic [15:0] pkt_length_i;
  logic [9:0]  pkt_channel_i;
  logic [31:0] pkt_pause_i;
  logic [57:0] descriptor_data_o;
  logic        descriptor_valid_o, descriptor_ready_i;
  logic        sts_busy_o, sts_done_o, sts_cfg_err_o;
  logic [3:0]  sts_fifo_level_o;
`ifdef GENERATOR_DESCRIPTOR_STAT_EN
  logic [31:0] sts_reject_cnt_o, sts_descr_cnt_o;
`endif

  generator_descriptor_fifo dut (
    .clk(clk), .reset(reset),
    .cntrl_start_i(cntrl_start_i), .cntrl_stop_i(cntrl_stop_i),
    .cntrl_auto_length_i(cntrl_auto_length_i), .cntrl_auto_channel_i(cntrl_auto_channel_i),
    .cntrl_auto_pause_i(cntrl_auto_pause_i), .cntrl_use_limit_transaction_i(cntrl_use_limit_transaction_i),
    .cntrl_fixed_length_i(cntrl_fixed_length_i), .cntrl_min_length_i(cntrl_min_length_i),
    .cntrl_max_length_i(cntrl_max_length_i),
    .cntrl_fixed_channel_i(cntrl_fixed_channel_i), .cntrl_min_channel_i(cntrl_min_channel_i),
    .cntrl_max_channel_i(cntrl_max_channel_i),
    .cntrl_fixed_pause_i(cntrl_fixed_pause_i), .cntrl_min_pause_i(cntrl_min_pause_i),
    .cntrl_max_pause_i(cntrl_max_pause_i),
    .cntrl_cnt_packet_i(cntrl_cnt_packet_i),
    .pkt_length_i(pkt_length_i), .pkt_channel_i(pkt_channel_i), .pkt_pause_i(pkt_pause_i),
    .descriptor_data_o(descriptor_data_o), .descriptor_valid_o(descriptor_valid_o),
    .descriptor_ready_i(descriptor_ready_i),
    .sts_busy_o(sts_busy_o), .sts_done_o(sts_done_o), .sts_cfg_err_o(sts_cfg_err_o),
    .sts_fifo_level_o(sts_fifo_level_o)
`ifdef GENERATOR_DESCRIPTOR_STAT_EN
    , .sts_reject_cnt_o(sts_reject_cnt_o), .sts_descr_cnt_o(sts_descr_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [57:0] got[$];
  int n_done, done_at, last_pop;
  int smp_lo = 0, smp_hi = 65535;
  logic [9:0] seq_ch;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 1: length biased towards 100; mode 2: channel counts up; else uniform in [smp_lo, smp_hi]
  task automatic drive_samples(input int m);
    if (m == 1) pkt_length_i = ($urandom_range(0, 3) == 0) ? 16'd100 : 16'($urandom);
    else        pkt_length_i = 16'($urandom_range(smp_lo, smp_hi));
    pkt_pause_i = $urandom;
    if (m == 2) begin
      pkt_channel_i = seq_ch;
      seq_ch = seq_ch + 10'd1;
    end else pkt_channel_i = 10'($urandom);
  endtask

  task automatic cfg_fixed(input int len, input int ch, input int pa, input bit lim, input int cnt);
    cntrl_auto_length_i = 1'b0; cntrl_auto_channel_i = 1'b0; cntrl_auto_pause_i = 1'b0;
    cntrl_fixed_length_i = 16'(len); cntrl_fixed_channel_i = 10'(ch); cntrl_fixed_pause_i = 32'(pa);
    cntrl_use_limit_transaction_i = lim; cntrl_cnt_packet_i = 32'(cnt);
  endtask

  task automatic start_run();
    cntrl_start_i = 1'b1;
    @(posedge clk); #1;
    cntrl_start_i = 1'b0;
  endtask

  task automatic hold_cycles(input int n, input int m);
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      drive_samples(m);
      descriptor_ready_i = 1'b0;
    end
  endtask

  // run until the block goes idle, recording every popped descriptor
  task automatic collect(input int budget, input int rmode, input int smode, input string tag);
    bit fin;
    got.delete(); n_done = 0; done_at = -1; last_pop = -1; fin = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      drive_samples(smode);
      descriptor_ready_i = (rmode == 0) ? 1'b1 : ($urandom_range(0, 9) < 7);
      if (descriptor_valid_o && descriptor_ready_i) begin
        got.push_back(descriptor_data_o);
        last_pop = c;
      end
      if (sts_done_o) begin n_done++; done_at = c; end
      if (!sts_busy_o) begin fin = 1; break; end
    end
    check({tag, "_finish"}, 64'(fin), 64'd1);
  endtask

  initial begin
    int bad, found, lmin, lmax, lim, fch, fpa;
    logic [57:0] exp_d;
    reset = 1'b1; cntrl_start_i = 1'b0; cntrl_stop_i = 1'b0;
    cfg_fixed(0, 0, 0, 1'b0, 0);
    cntrl_min_length_i = '0; cntrl_max_length_i = '0;
    cntrl_min_channel_i = '0; cntrl_max_channel_i = '0;
    cntrl_min_pause_i = '0; cntrl_max_pause_i = '0;
    pkt_length_i = '0; pkt_channel_i = '0; pkt_pause_i = '0;
    descriptor_ready_i = 1'b1; seq_ch = '0;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 64'(descriptor_valid_o), 0);
    check("rst_busy", 64'(sts_busy_o), 0);
    check("rst_level", 64'(sts_fifo_level_o), 0);
    check("rst_data", 64'(descriptor_data_o), 0);
    check("rst_done_err", 64'({sts_done_o, sts_cfg_err_o}), 0);
    reset = 1'b0;

    // all fixed, limit 4, ready=1: first valid three cycles after start
    cfg_fixed(64, 3, 10, 1'b1, 4);
    exp_d = {10'd3, 32'd10, 16'd64};
    start_run();
    @(negedge clk); check("fix_lat1", 64'(descriptor_valid_o), 0);
    @(negedge clk); check("fix_lat2", 64'(descriptor_valid_o), 0);
    @(posedge clk); #1;
    check("fix_lat3", 64'(descriptor_valid_o), 1);
    check("fix_head", 64'(descriptor_data_o), 64'(exp_d));
    collect(100, 0, 0, "fix");
    check("fix_count", 64'(got.size()), 4);
    bad = 0;
    foreach (got[i]) if (got[i] !== exp_d) bad++;
    check("fix_data", 64'(bad), 0);
    check("fix_done_n", 64'(n_done), 1);
    check("fix_done_when", 64'(done_at), 64'(last_pop + 1));

    // auto length pinned to 100
    cfg_fixed(0, 1, 2, 1'b1, 6);
    cntrl_auto_length_i = 1'b1; cntrl_min_length_i = 16'd100; cntrl_max_length_i = 16'd100;
    start_run();
    collect(2000, 0, 1, "a100");
    check("a100_count", 64'(got.size()), 6);
    bad = 0;
    foreach (got[i]) if (got[i] !== {10'd1, 32'd2, 16'd100}) bad++;
    check("a100_data", 64'(bad), 0);
    check("a100_done", 64'(n_done), 1);
`ifdef GENERATOR_DESCRIPTOR_STAT_EN
    check("a100_rej_pos", 64'(sts_reject_cnt_o != 0), 1);
    check("a100_descr", 64'(sts_descr_cnt_o), 6);
`endif

    // limit 20 with consumer stalled: fill then drain in order
    cfg_fixed(5, 0, 7, 1'b1, 20);
    cntrl_auto_channel_i = 1'b1; cntrl_min_channel_i = 10'd0; cntrl_max_channel_i = 10'd1023;
    seq_ch = '0; descriptor_ready_i = 1'b0;
    start_run();
    hold_cycles(40, 2);
    check("fill_level", 64'(sts_fifo_level_o), 8);
    check("fill_valid_busy", 64'({descriptor_valid_o, sts_busy_o}), 64'(2'b11));
    collect(300, 0, 2, "fill");
    check("fill_count", 64'(got.size()), 20);
    bad = 0;
    foreach (got[i]) begin
      if (got[i][47:0] !== {32'd7, 16'd5}) bad++;
      if (i > 0 && got[i][57:48] <= got[i-1][57:48]) bad++;
    end
    check("fill_order", 64'(bad), 0);
    check("fill_done", 64'(n_done), 1);

    // rejected starts
    cfg_fixed(8, 1, 1, 1'b1, 3);
    cntrl_auto_pause_i = 1'b1; cntrl_min_pause_i = 32'd50; cntrl_max_pause_i = 32'd40;
    start_run();
    check("err_pulse", 64'(sts_cfg_err_o), 1);
    check("err_idle", 64'({sts_busy_o, descriptor_valid_o}), 0);
    @(posedge clk); #1;
    check("err_one_cycle", 64'(sts_cfg_err_o), 0);
    cfg_fixed(8, 1, 1, 1'b1, 0);
    start_run();
    check("err_cnt0", 64'({sts_cfg_err_o, sts_busy_o}), 64'(2'b10));

    // unlimited run stopped with five queued
    cfg_fixed(9, 2, 4, 1'b0, 0);
    descriptor_ready_i = 1'b0;
    start_run();
    found = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (sts_fifo_level_o == 4'd5) begin found = 1; break; end
    end
    check("stop_reach5", 64'(found), 1);
    cntrl_stop_i = 1'b1;
    @(posedge clk); #1;
    cntrl_stop_i = 1'b0;
    check("stop_valid", 64'(descriptor_valid_o), 0);
    check("stop_level", 64'(sts_fifo_level_o), 0);
    check("stop_busy_done", 64'({sts_busy_o, sts_done_o}), 0);
    hold_cycles(4, 0);
    check("stop_stays_idle", 64'({sts_busy_o, sts_done_o, descriptor_valid_o}), 0);

    // reset while holding in PUSH with a full FIFO, then restart
    cfg_fixed(11, 5, 6, 1'b1, 20);
    start_run();
    hold_cycles(30, 0);
    check("rstp_full", 64'(sts_fifo_level_o), 8);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rstp_outs", 64'({descriptor_valid_o, sts_busy_o, sts_done_o, sts_cfg_err_o, sts_fifo_level_o}), 0);
    check("rstp_data", 64'(descriptor_data_o), 0);
`ifdef GENERATOR_DESCRIPTOR_STAT_EN
    check("rstp_stats", 64'({sts_reject_cnt_o, sts_descr_cnt_o}), 0);
`endif
    cfg_fixed(11, 5, 6, 1'b1, 3);
    start_run();
    collect(100, 0, 0, "rstp");
    check("rstp_count", 64'(got.size()), 3);
    check("rstp_done", 64'(n_done), 1);

    // randomised runs: auto length in a random window, random ready
    for (int it = 0; it < 4; it++) begin
      lmin = $urandom_range(32, 1500);
      lmax = lmin + $urandom_range(0, 100);
      lim  = $urandom_range(3, 12);
      fch  = $urandom_range(0, 1023);
      fpa  = $urandom;
      smp_lo = lmin - 20; smp_hi = lmax + 20;
      cfg_fixed(1, fch, fpa, 1'b1, lim);
      cntrl_auto_length_i = 1'b1;
      cntrl_min_length_i = 16'(lmin); cntrl_max_length_i = 16'(lmax);
      start_run();
      collect(4000, 1, 0, "rnd");
      check("rnd_count", 64'(got.size()), 64'(lim));
      bad = 0;
      foreach (got[i]) begin
        if (got[i][57:48] !== 10'(fch) || got[i][47:16] !== 32'(fpa)) bad++;
        if (int'(got[i][15:0]) < lmin || int'(got[i][15:0]) > lmax) bad++;
      end
      check("rnd_fields", 64'(bad), 0);
      check("rnd_done", 64'(n_done), 1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
